// File: rtl/float_acc.sv
// float_acc: multi-cycle IEEE 754 single-precision accumulator fed by a product stream
//
// Ports:
//    clk_i        rising-edge clock
//    rst_ni       synchronous active-low reset
//    in_valid_i   product word valid
//    in_ready_o   word can be accepted this cycle (IDLE only)
//    in_data_i    product word, IEEE 754 layout
//    in_last_i    word closes the current sum
//    out_valid_o  sum word valid (OUT state)
//    out_ready_i  consumer accepts the sum
//    out_data_o   accumulated sum, held while out_valid_o=1
//    busy_o       FSM not in IDLE
//
// Number conventions: truncation only, exponent 0 is zero (incl. -0), no NaN/Inf.
// Optional macro FLOAT_ACC_FAST_ALIGN_EN: barrel shifter + leading-zero count make
// ALIGN and NORM single-cycle (fixed 5-cycle latency); results are bit-identical.
module float_acc #(
   parameter int E     = 8,
   parameter int M     = 23,
   parameter int Width = 1 + E + M
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [Width-1:0] in_data_i,
   input  logic             in_last_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [Width-1:0] out_data_o,
   output logic             busy_o
);
   // working mantissa: hidden bit, M fraction bits, 2 guard bits
   localparam int MW = M + 3;
   localparam int XW = E + 1;
   localparam logic [E-1:0]  FAR  = E'(MW);
   localparam logic [XW-1:0] EMAX = {1'b0, {E{1'b1}}};
`ifdef FLOAT_ACC_FAST_ALIGN_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, FIN, OUT} state_t;

   state_t        state_q, state_d;
   logic [Width-1:0] acc_q, acc_d;
   logic          last_q, last_d;
   logic          sa_q, sa_d, sb_q, sb_d;
   logic [E-1:0]  ea_q, ea_d, eb_q, eb_d;
   logic [MW-1:0] ma_q, ma_d, mb_q, mb_d;
   logic          sr_q, sr_d;
   logic [XW-1:0] er_q, er_d;
   logic [MW:0]   mr_q, mr_d;

   logic [E-1:0]  in_e, acc_e;
   logic          in_z;
   assign in_e  = in_data_i[Width-2:M];
   assign acc_e = acc_q[Width-2:M];
   assign in_z  = in_e == '0;

   // alignment: the operand with the smaller exponent is shifted toward the larger
   logic          a_small, align_done;
   logic [E-1:0]  ediff, el, es_n;
   logic [MW-1:0] ms, ms_n;
`ifdef FLOAT_ACC_FAST_ALIGN_EN
   always_comb begin
      a_small    = ea_q < eb_q;
      ediff      = a_small ? eb_q - ea_q : ea_q - eb_q;
      el         = a_small ? eb_q : ea_q;
      ms         = a_small ? ma_q : mb_q;
      ms_n       = ms >> ediff;
      es_n       = el;
      align_done = 1'b1;
   end
`else
   logic          far;
   logic [E-1:0]  es;
   always_comb begin
      a_small    = ea_q < eb_q;
      ediff      = a_small ? eb_q - ea_q : ea_q - eb_q;
      far        = ediff >= FAR;
      el         = a_small ? eb_q : ea_q;
      es         = a_small ? ea_q : eb_q;
      ms         = a_small ? ma_q : mb_q;
      ms_n       = far ? '0 : ms >> 1;
      es_n       = far ? el : es + E'(1);
      // the shift that closes the gap also leaves the state
      align_done = far || ediff <= E'(1);
   end
`endif

   // signed-magnitude add of the aligned mantissas
   logic        same, a_ge, sum_z, sgn;
   logic [MW:0] sum;
   always_comb begin
      same  = sa_q == sb_q;
      a_ge  = ma_q >= mb_q;
      sum   = same ? {1'b0, ma_q} + {1'b0, mb_q}
            : a_ge ? {1'b0, ma_q} - {1'b0, mb_q} : {1'b0, mb_q} - {1'b0, ma_q};
      sum_z = sum == '0;
      sgn   = (same || a_ge) ? sa_q : sb_q;
   end

   // normalisation step: carry -> one right shift, else left shifts until hidden bit set
   logic [MW:0]   nm;
   logic [XW-1:0] ne;
   logic          uf, of, norm_done;
`ifdef FLOAT_ACC_FAST_ALIGN_EN
   logic [XW-1:0] lz;
   always_comb begin
      lz = '0;
      for (int i = 0; i < MW; i++) lz = mr_q[i] ? XW'(MW - 1 - i) : lz;
   end
   always_comb begin
      nm        = mr_q[MW] ? mr_q >> 1 : mr_q << lz;
      ne        = mr_q[MW] ? er_q + XW'(1) : er_q - lz;
      // a zero sum has er_q=0 and lz=0, so it also lands here
      uf        = !mr_q[MW] && er_q <= lz;
      of        = !uf && ne >= EMAX;
      norm_done = 1'b1;
   end
`else
   always_comb begin
      nm        = mr_q[MW] ? mr_q >> 1 : mr_q[MW-1] ? mr_q : mr_q << 1;
      ne        = mr_q[MW] ? er_q + XW'(1) : mr_q[MW-1] ? er_q : er_q - XW'(1);
      uf        = ne == '0;
      of        = ne >= EMAX;
      norm_done = mr_q[MW] || mr_q[MW-1] || uf;
   end
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = in_valid_i ? ALIGN : IDLE;
         ALIGN:   state_d = align_done ? ADD : ALIGN;
         ADD:     state_d = (sum_z && !FAST) ? FIN : NORM;
         NORM:    state_d = norm_done ? FIN : NORM;
         FIN:     state_d = last_q ? OUT : IDLE;
         OUT:     state_d = out_ready_i ? IDLE : OUT;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      acc_d  = acc_q;
      last_d = last_q;
      sa_d   = sa_q;
      sb_d   = sb_q;
      ea_d   = ea_q;
      eb_d   = eb_q;
      ma_d   = ma_q;
      mb_d   = mb_q;
      sr_d   = sr_q;
      er_d   = er_q;
      mr_d   = mr_q;
      case (state_q)
         IDLE: if (in_valid_i) begin
            sa_d   = acc_q[Width-1];
            ea_d   = acc_e;
            ma_d   = acc_e == '0 ? '0 : {1'b1, acc_q[M-1:0], 2'b00};
            sb_d   = !in_z && in_data_i[Width-1];
            eb_d   = in_e;
            mb_d   = in_z ? '0 : {1'b1, in_data_i[M-1:0], 2'b00};
            last_d = in_last_i;
         end
         ALIGN: if (ediff != '0) begin
            if (a_small) begin
               ma_d = ms_n;
               ea_d = es_n;
            end else begin
               mb_d = ms_n;
               eb_d = es_n;
            end
         end
         ADD: begin
            sr_d = !sum_z && sgn;
            er_d = sum_z ? '0 : {1'b0, ea_q};
            mr_d = sum;
         end
         NORM: begin
            sr_d = sr_q && !uf;
            er_d = uf ? '0 : of ? EMAX - XW'(1) : ne;
            mr_d = uf ? '0 : of ? {1'b0, {MW{1'b1}}} : nm;
         end
         // guard bits are dropped here (truncation)
         FIN:     acc_d = {sr_q, er_q[E-1:0], mr_q[MW-2:2]};
         OUT:     acc_d = out_ready_i ? '0 : acc_q;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         acc_q   <= '0;
         last_q  <= 1'b0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         ea_q    <= '0;
         eb_q    <= '0;
         ma_q    <= '0;
         mb_q    <= '0;
         sr_q    <= 1'b0;
         er_q    <= '0;
         mr_q    <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         last_q  <= last_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         ea_q    <= ea_d;
         eb_q    <= eb_d;
         ma_q    <= ma_d;
         mb_q    <= mb_d;
         sr_q    <= sr_d;
         er_q    <= er_d;
         mr_q    <= mr_d;
      end
   end

   always_comb begin
      in_ready_o  = state_q == IDLE;
      out_valid_o = state_q == OUT;
      busy_o      = state_q != IDLE;
      out_data_o  = out_valid_o ? acc_q : '0;
   end
endmodule

// File: doc/float_acc.md
Name: float_acc

Overview:
- Multi-cycle IEEE 754 single-precision accumulator, directly downstream of the float multiplier.
- Consumes a stream of products over a valid/ready handshake and sums them into an internal accumulator.
- Emits the sum when the element flagged last has been added, then clears to +0.
- Uses the multiplier's number conventions: no rounding (truncate), exponent 0 treated as zero, no NaN/Inf handling.

Parameters:
- E, 8, exponent width
- M, 23, mantissa width (hidden bit excluded)
- Width, 32, word width (1 + E + M)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  product word valid
- in_ready  output  1  block can accept a word this cycle
- in_data  input  Width  product word, IEEE 754 layout
- in_last  input  1  word closes the current sum
- out_valid  output  1  sum word valid
- out_ready  input  1  consumer accepts sum
- out_data  output  Width  accumulated sum
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge) forces: FSM=IDLE, accumulator=+0 (all zeros), in_ready=1, out_valid=0, out_data=0, busy=0. Reset mid-operation discards all partial state.
- Input transfer occurs on in_valid & in_ready. in_ready=1 only in IDLE.
- Output transfer occurs on out_valid & out_ready. out_data is held stable while out_valid=1.
- States:
  - IDLE: on transfer, latch operand B=in_data and last flag, go to ALIGN. Any operand with exponent 0 is flushed to +0.
  - ALIGN: hidden bit 1 plus 2 extra low bits, (M+3)-bit mantissas. Operand with the smaller exponent is shifted right 1 bit per cycle, its exponent incremented each shift, until the exponents match. If the exponent difference is >= M+3, the smaller operand becomes 0 in one cycle. Difference 0 costs 1 cycle.
  - ADD: same signs add magnitudes; different signs subtract the smaller magnitude from the larger, taking the larger's sign. Exact-zero result gives +0 and goes to finish. One cycle.
  - NORM: carry-out gives one right shift with exponent+1. Otherwise shift left 1 bit per cycle, exponent-1, until the hidden bit is set.
    - Exponent reaching 0 means underflow: result +0.
    - Exponent reaching 255 means overflow: clamp to sign, exponent 254, mantissa all ones.
    - Extra low bits are truncated on write-back.
  - Finish: write the result to the accumulator. If last=1, go to OUT. Else go to IDLE.
  - OUT: out_valid=1, out_data=accumulator. On out_ready, clear the accumulator to +0 and return to IDLE.
- Latency, input accept to out_valid with last=1: 1 + align cycles + 1 + norm cycles + 1.
- Back-to-back sums work: in_ready returns in the cycle after the OUT handshake.
- A lone last word with an empty accumulator outputs that word, flushed/truncated.
- Negative zero inputs are treated as +0.

Optional Feature:
- FLOAT_ACC_FAST_ALIGN_EN
- Defined: ALIGN and NORM each complete in exactly 1 cycle, using a barrel shifter and a leading-zero count. Fixed latency of 5 cycles, accept to out_valid.
- Undefined: bit-serial shifting as above, with variable latency.
- Numeric results are bit-identical in both builds.

Test Plan:
- Reset mid-ALIGN after accepting 0x3F800000, release -> in_ready=1, out_valid=0, then 0x40000000 with last -> out_data 0x40000000.
- 0x3F800000 then 0x40000000 (last) -> out_data 0x40400000 (3.0). With the macro, out_valid arrives exactly 5 cycles after the second accept.
- 0x3FC00000 then 0xBFC00000 (last) -> 0x00000000. Then 0x3F800000 (last) -> 0x3F800000, confirming the accumulator was cleared.
- 0x3F800000 then 0x33800000 (last) -> 0x3F800000, since 2^-24 is truncated.
- 0x7F7FFFFF twice (last) -> 0x7F7FFFFF (overflow clamp). Also 0x00400000 (last) -> 0x00000000 (flush).
- Hold out_ready=0 for 10 cycles with a sum pending -> out_valid and out_data are stable, in_ready=0, and a word presented on in_data is not accepted.
